jtag_ssram_stream_reader: RTL
=============================

Name: jtag_ssram_stream_reader

Overview:
- System-clock reader for port B of the 512x32 dual-port SSRAM in the JTAG interface. The JTAG side writes captured words through port A.
- On a start command, this block reads a run of words starting at a given address and streams them out over a valid/ready interface.
- It hides the RAM's one-cycle registered read latency and sustains one word per cycle while the consumer is ready.

Parameters:
- FIFO_DEPTH, 4, output buffer depth in words; must be a power of two, minimum 2.

Ports:
- clock  in  1  system clock; also drives RAM clockB.
- reset  in  1  synchronous reset, active-high.
- start  in  1  single-cycle command strobe; honoured only when busy=0.
- startAddress  in  9  first RAM word address.
- wordCount  in  10  number of words to read, 0..512; values above 512 are treated as 512.
- ramAddress  out  9  to RAM addressB.
- ramWriteEnable  out  1  to RAM writeEnableB; constant 0.
- ramDataIn  in  32  from RAM dataOutB; valid the cycle after an address is presented.
- dataOut  out  32  stream data (FIFO head).
- dataValid  out  1  stream valid.
- dataReady  in  1  stream ready from the consumer.
- busy  out  1  a transfer is in progress.
- done  out  1  one-cycle pulse at the end of a transfer.

Behaviour:
- Reset, and any cycle with reset=1 (including mid-transfer):
  - State returns to IDLE; FIFO is flushed; the pending flag and all counters are cleared.
  - busy=0, done=0, dataValid=0, dataOut=0, ramAddress=0.
  - No residual words are emitted after reset.
- States:
  - IDLE: start=1 in cycle T latches nextAddr=startAddress, issueLeft=min(wordCount,512) and popLeft=issueLeft, then moves to RUN. busy=1 from T+1.
  - If the latched count is 0, the block goes to FINISH instead: no RAM reads, done=1 in T+1, busy=0 in T+1.
  - RUN: issues reads and drains the FIFO. When popLeft reaches 0, move to FINISH.
  - FINISH: done=1 and busy=0 for exactly that one cycle, then return to IDLE.
  - start while busy=1 or in FINISH is ignored; latched values are not disturbed.
- Read issue:
  - ramAddress is combinationally equal to nextAddr.
  - A read is "issued" in a cycle when state=RUN, issueLeft>0, and (fifoCount + pending - pop) < FIFO_DEPTH. Here pop = dataValid & dataReady in that cycle.
  - On issue: nextAddr increments modulo 512 (511 wraps to 0), issueLeft decrements, and pending is set for the next cycle.
- Capture:
  - In the cycle after an issue (pending=1), ramDataIn is written into the FIFO at the closing edge. It appears at dataOut no earlier than the following cycle.
  - Words enter the FIFO in issue order. The FIFO never overflows; the credit check above guarantees this.
- Stream:
  - dataValid = (fifoCount > 0). dataOut = FIFO head.
  - A transfer occurs on dataValid & dataReady. popLeft decrements per transfer.
  - dataOut and dataValid are held stable while dataValid=1 and dataReady=0.
- Latency: start at T, first read issued in T+1, first dataValid in T+3.
- Throughput: with dataReady held at 1, one word per cycle. The last of N words transfers in T+2+N; done pulses in T+3+N.
- Simultaneous FIFO push and pop in the same cycle leaves fifoCount unchanged.
- The RAM may be written via port A during a read. Whatever the RAM returns is passed through unmodified; no coherence is enforced.

Test Plan:
- Basic run: RAM preloaded so word[i]=0xA5000000+i. start at cycle T with startAddress=0x010, wordCount=4, dataReady=1 -> dataOut 0xA5000010..0xA5000013 on consecutive cycles T+3..T+6; done=1 in T+7; busy high T+1..T+6.
- Wrap-around: startAddress=0x1FE, wordCount=4 -> ramAddress sequence 0x1FE, 0x1FF, 0x000, 0x001; four words emitted in that order.
- Backpressure: wordCount=8, dataReady toggles 1,0,0,1,... -> all 8 words delivered in order with none dropped or duplicated; fifoCount never exceeds 4; dataOut stable while stalled.
- Zero count and clamping: wordCount=0 -> done in T+1, no dataValid. wordCount=700 from address 0 -> exactly 512 words emitted.
- Ignored start: start pulsed mid-transfer with a different address/count -> the original transfer completes unchanged, with no extra words.
- Reset mid-transfer: reset asserted after 3 of 10 words -> next cycle busy=0, dataValid=0, done=0. A new start afterwards runs cleanly from its own address.

Source files
------------

// File: rtl/jtag_ssram_stream_reader.sv
// Port-B reader for the JTAG capture SSRAM: reads a run of words and streams them
// over valid/ready, hiding the RAM's one-cycle registered read latency.
module jtag_ssram_stream_reader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  startAddress,
  input  logic [9:0]  wordCount,
  output logic [8:0]  ramAddress,
  output logic        ramWriteEnable,
  input  logic [31:0] ramDataIn,
  output logic [31:0] dataOut,
  output logic        dataValid,
  input  logic        dataReady,
  output logic        busy,
  output logic        done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t      state_reg, state_next;
  logic [8:0]  next_addr_reg, next_addr_next;
  logic [9:0]  issue_left_reg, issue_left_next;
  logic [9:0]  pop_left_reg, pop_left_next;
  logic        pending_reg, pending_next;

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   mem_reg [FIFO_DEPTH];

  logic        pop;
  logic        push;
  logic        issue;
  logic [CW:0] credit;
  logic [9:0]  clamped_count;

  assign clamped_count = (wordCount > 10'd512) ? 10'd512 : wordCount;

  assign dataValid = (count_reg != '0);
  assign dataOut   = dataValid ? mem_reg[rd_ptr_reg] : 32'd0;
  assign pop       = dataValid & dataReady;
  assign push      = pending_reg;

  // Words already stored plus the one in flight from the RAM, minus the one leaving now.
  assign credit = {1'b0, count_reg} + (CW + 1)'(pending_reg) - (CW + 1)'(pop);
  assign issue  = (state_reg == RUN) && (issue_left_reg != 10'd0) && (credit < DEPTH_C);

  assign ramAddress     = next_addr_reg;
  assign ramWriteEnable = 1'b0;
  assign busy           = (state_reg == RUN);
  assign done           = (state_reg == FINISH);

  always_comb begin
    state_next      = state_reg;
    next_addr_next  = next_addr_reg;
    issue_left_next = issue_left_reg;
    pop_left_next   = pop_left_reg;
    pending_next    = issue;
    case (state_reg)
      IDLE: begin
        if (start) begin
          next_addr_next  = startAddress;
          issue_left_next = clamped_count;
          pop_left_next   = clamped_count;
          state_next      = (clamped_count == 10'd0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          next_addr_next  = next_addr_reg + 9'd1;
          issue_left_next = issue_left_reg - 10'd1;
        end
        if (pop) begin
          pop_left_next = pop_left_reg - 10'd1;
          if (pop_left_reg == 10'd1) begin
            state_next = FINISH;
          end
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      next_addr_reg  <= '0;
      issue_left_reg <= '0;
      pop_left_reg   <= '0;
      pending_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      next_addr_reg  <= next_addr_next;
      issue_left_reg <= issue_left_next;
      pop_left_reg   <= pop_left_next;
      pending_reg    <= pending_next;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
    always_ff @(posedge clock) begin
      if (reset) begin
        mem_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg == PW'(gi))) begin
        mem_reg[gi] <= ramDataIn;
      end
    end
  end

endmodule
